mmio_dmem: RTL and testbench

- Responder for the single-cycle core's data-memory port, which is driven by memwrite, memaddr, memwritedata and memreaddata.
- Contains a word-addressed data RAM plus a small memory-mapped I/O page: a GPIO output register, a free-running cycle counter, and a compare timer with an interrupt flag.
- Reads are combinational, so the core gets data in the same cycle. Writes commit on the rising clock edge.

---
 rtl/mmio_dmem.sv | 172 +++++++++++++++++
 tb/tb_mmio_dmem.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_dmem.sv
// mmio_dmem: data-memory responder for the single-cycle core.
// Word-addressed RAM at 0x0000_0000, plus an IO page at 0xFFFF_0000 that holds
// the GPIO output register, a free-running cycle counter and a compare timer.
// Reads are combinational. Writes commit on the rising edge of clk.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   memwrite     write strobe from the core
//   memaddr      byte address; bits [1:0] are ignored
//   memwritedata write data
//   memreaddata  combinational read data for memaddr
//   gpio_out     GPIO register value
//   timer_irq    timer EXPIRED flag
//
// Timer state
//   state   | meaning
//   EN=0    | idle: COUNT holds and EXPIRED is not touched
//   EN=1    | counting: COUNT increments until it equals CMP
//   match   | EXPIRED set; AUTO=1 reloads COUNT to 0, AUTO=0 clears EN
module mmio_dmem #(
   parameter int RAM_WORDS = 64,
   parameter int GPIO_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [31:0]       memaddr,
   input  logic [31:0]       memwritedata,
   output logic [31:0]       memreaddata,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam int          AW          = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_WORDS_L = RAM_WORDS;

   localparam logic [7:0] OFF_GPIO  = 8'h00;
   localparam logic [7:0] OFF_CYCLE = 8'h04;
   localparam logic [7:0] OFF_CMP   = 8'h08;
   localparam logic [7:0] OFF_CTRL  = 8'h0C;
   localparam logic [7:0] OFF_COUNT = 8'h10;

   logic [31:0] mem_q [RAM_WORDS];

   logic [GPIO_W-1:0] gpio_q, gpio_d;
   logic [31:0]       cycle_q, cycle_d;
   logic [31:0]       cmp_q, cmp_d;
   logic [31:0]       count_q, count_d;
   logic              en_q, en_d;
   logic              auto_q, auto_d;
   logic              expired_q, expired_d;

   logic          ram_hit;
   logic          io_hit;
   logic [AW-1:0] ram_idx;
   logic [7:0]    io_off;
   logic          wr_gpio, wr_cycle, wr_cmp, wr_ctrl, wr_count;
   logic          match;
   logic          expired_set;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^memaddr[1:0];

   // The full 14-bit word index is compared so addresses past the RAM do not alias.
   assign ram_hit = (memaddr[31:16] == 16'h0) && ({18'd0, memaddr[15:2]} < RAM_WORDS_L);
   assign io_hit  = (memaddr[31:8] == 24'hFFFF00);
   assign ram_idx = memaddr[2 +: AW];
   assign io_off  = memaddr[7:0];

   assign wr_gpio  = memwrite && io_hit && (io_off == OFF_GPIO);
   assign wr_cycle = memwrite && io_hit && (io_off == OFF_CYCLE);
   assign wr_cmp   = memwrite && io_hit && (io_off == OFF_CMP);
   assign wr_ctrl  = memwrite && io_hit && (io_off == OFF_CTRL);
   assign wr_count = memwrite && io_hit && (io_off == OFF_COUNT);

   assign match = (count_q == cmp_q);

   always_ff @(posedge clk) begin
      if (memwrite && ram_hit) begin
         mem_q[ram_idx] <= memwritedata;
      end
   end

   always_comb begin
      gpio_d      = gpio_q;
      cycle_d     = cycle_q + 32'd1;
      cmp_d       = cmp_q;
      count_d     = count_q;
      en_d        = en_q;
      auto_d      = auto_q;
      expired_set = 1'b0;

      // A COUNT write replaces the whole timer step on that edge, so a pending
      // match neither sets EXPIRED nor clears EN.
      if (en_q && !wr_count) begin
         if (!match) begin
            count_d = count_q + 32'd1;
         end else begin
            expired_set = 1'b1;
            if (auto_q) begin
               count_d = 32'd0;
            end else begin
               en_d = 1'b0;
            end
         end
      end

      expired_d = expired_q | expired_set;

      if (wr_gpio) begin
         gpio_d = memwritedata[GPIO_W-1:0];
      end
      if (wr_cycle) begin
         cycle_d = memwritedata;
      end
      if (wr_cmp) begin
         cmp_d = memwritedata;
      end
      if (wr_count) begin
         count_d = memwritedata;
      end
      if (wr_ctrl) begin
         en_d   = memwritedata[0];
         auto_d = memwritedata[1];
         // Write-1-to-clear; a match on the same edge keeps the flag set.
         if (memwritedata[2] && !expired_set) begin
            expired_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_q    <= '0;
         cycle_q   <= '0;
         cmp_q     <= '0;
         count_q   <= '0;
         en_q      <= 1'b0;
         auto_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         gpio_q    <= gpio_d;
         cycle_q   <= cycle_d;
         cmp_q     <= cmp_d;
         count_q   <= count_d;
         en_q      <= en_d;
         auto_q    <= auto_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      memreaddata = 32'd0;
      if (ram_hit) begin
         memreaddata = mem_q[ram_idx];
      end else if (io_hit) begin
         case (io_off)
            OFF_GPIO:  memreaddata = 32'(gpio_q);
            OFF_CYCLE: memreaddata = cycle_q;
            OFF_CMP:   memreaddata = cmp_q;
            OFF_CTRL:  memreaddata = {29'd0, expired_q, auto_q, en_q};
            OFF_COUNT: memreaddata = count_q;
            default:   memreaddata = 32'd0;
         endcase
      end
   end

   assign gpio_out  = gpio_q;
   assign timer_irq = expired_q;

endmodule

// File: tb/tb_mmio_dmem.sv
// Directed bench for mmio_dmem: a vector table for RAM, GPIO and address decode,
// followed by hand-written sequences for the timer, cycle counter and reset.
module tb_mmio_dmem;

   localparam logic [31:0] A_GPIO  = 32'hFFFF0000;
   localparam logic [31:0] A_CYCLE = 32'hFFFF0004;
   localparam logic [31:0] A_CMP   = 32'hFFFF0008;
   localparam logic [31:0] A_CTRL  = 32'hFFFF000C;
   localparam logic [31:0] A_COUNT = 32'hFFFF0010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] memaddr = 32'd0;
   logic [31:0] memwritedata = 32'd0;
   logic [31:0] memreaddata;
   logic [15:0] gpio_out;
   logic        timer_irq;

   int n_vec = 0;
   int n_err = 0;

   mmio_dmem #(.RAM_WORDS(64), .GPIO_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .memreaddata  (memreaddata),
      .gpio_out     (gpio_out),
      .timer_irq    (timer_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [15:0] exp_gpio;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one bus cycle and let it commit on the next rising edge.
   task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      memwrite     = we;
      memaddr      = addr;
      memwritedata = wd;
      @(posedge clk);
      #1;
      memwrite = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      memwrite = 1'b0;
      memaddr  = addr;
      #1;
      chk(name, memreaddata, exp);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 32'h00000008, 32'hDEADBEEF, 1'b0, 32'h0,        16'h0};
      tbl[1]  = '{1'b0, 32'h00000008, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0};
      tbl[2]  = '{1'b0, 32'h0000000B, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0};
      tbl[3]  = '{1'b1, 32'h00000100, 32'h12345678, 1'b1, 32'h0,        16'h0};
      tbl[4]  = '{1'b0, 32'h00000100, 32'h0,        1'b1, 32'h0,        16'h0};
      tbl[5]  = '{1'b1, 32'h000000FC, 32'hA5A50001, 1'b0, 32'h0,        16'h0};
      tbl[6]  = '{1'b0, 32'h000000FC, 32'h0,        1'b1, 32'hA5A50001, 16'h0};
      tbl[7]  = '{1'b1, 32'h00010008, 32'h11111111, 1'b1, 32'h0,        16'h0};
      tbl[8]  = '{1'b0, 32'h00000008, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0};
      tbl[9]  = '{1'b1, A_GPIO,       32'h0001ABCD, 1'b1, 32'h0,        16'hABCD};
      tbl[10] = '{1'b0, A_GPIO,       32'h0,        1'b1, 32'h0000ABCD, 16'hABCD};
      tbl[11] = '{1'b0, 32'hFFFF0014, 32'h0,        1'b1, 32'h0,        16'hABCD};
      tbl[12] = '{1'b1, 32'hFFFF0020, 32'hFFFFFFFF, 1'b1, 32'h0,        16'hABCD};
      tbl[13] = '{1'b0, 32'hFFFE0000, 32'h0,        1'b1, 32'h0,        16'hABCD};
      tbl[14] = '{1'b1, A_CMP,        32'h00000055, 1'b1, 32'h0,        16'hABCD};
      tbl[15] = '{1'b0, A_CMP,        32'h0,        1'b1, 32'h00000055, 16'hABCD};

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_irq", 32'(timer_irq), 32'h0);
      reset = 1'b1;
      rd(A_COUNT, 32'h0, "rst_count");
      rd(A_CTRL, 32'h0, "rst_ctrl");
      rd(A_CYCLE, 32'h0, "rst_cycle");
      @(posedge clk);
      #1;

      // Table: read during the cycle (before commit), gpio_out after the edge
      for (int i = 0; i < 16; i++) begin
         memwrite     = tbl[i].we;
         memaddr      = tbl[i].addr;
         memwritedata = tbl[i].wd;
         #1;
         if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), memreaddata, tbl[i].exp_rd);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(tbl[i].exp_gpio));
      end
      memwrite = 1'b0;

      // One-shot timer
      step(1'b1, A_CMP, 32'd3);
      step(1'b1, A_COUNT, 32'd0);
      step(1'b1, A_CTRL, 32'h1);
      rd(A_COUNT, 32'd0, "os_count0");
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, A_COUNT, 32'd0);
         rd(A_COUNT, 32'(k), $sformatf("os_count%0d", k));
         chk("os_irq_low", 32'(timer_irq), 32'h0);
      end
      step(1'b0, A_COUNT, 32'd0);
      chk("os_irq_high", 32'(timer_irq), 32'h1);
      rd(A_CTRL, 32'h4, "os_ctrl");
      rd(A_COUNT, 32'd3, "os_count_hold");
      step(1'b0, A_COUNT, 32'd0);
      rd(A_COUNT, 32'd3, "os_count_hold2");
      step(1'b1, A_CTRL, 32'h4);
      chk("os_irq_clr", 32'(timer_irq), 32'h0);

      // Auto-reload: COUNT 0,1,2,0,1,2 with EXPIRED rising on the first wrap
      step(1'b1, A_CMP, 32'd2);
      step(1'b1, A_COUNT, 32'd0);
      step(1'b1, A_CTRL, 32'h3);
      rd(A_COUNT, 32'd0, "ar_count_start");
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, A_COUNT, 32'd0);
         rd(A_COUNT, 32'(k % 3), $sformatf("ar_count_e%0d", k));
         chk($sformatf("ar_irq_e%0d", k), 32'(timer_irq), (k >= 3) ? 32'h1 : 32'h0);
      end
      // COUNT==CMP now: clear coinciding with a match keeps EXPIRED set
      step(1'b1, A_CTRL, 32'h7);
      chk("ar_clr_vs_set", 32'(timer_irq), 32'h1);
      rd(A_CTRL, 32'h7, "ar_ctrl");
      rd(A_COUNT, 32'd0, "ar_reload");
      step(1'b1, A_CTRL, 32'h7);
      chk("ar_clr", 32'(timer_irq), 32'h0);
      rd(A_CTRL, 32'h3, "ar_ctrl_clr");
      step(1'b0, A_COUNT, 32'd0);
      rd(A_COUNT, 32'd2, "ar_pre_match");
      // COUNT write overrides the match on this edge
      step(1'b1, A_COUNT, 32'h10);
      rd(A_COUNT, 32'h10, "cw_load");
      chk("cw_no_expire", 32'(timer_irq), 32'h0);
      rd(A_CTRL, 32'h3, "cw_en_kept");
      step(1'b1, A_CTRL, 32'h0);
      rd(A_COUNT, 32'h11, "cw_last_inc");
      step(1'b0, A_COUNT, 32'd0);
      rd(A_COUNT, 32'h11, "dis_hold");

      // CMP=0, COUNT=0 expires on the first enabled edge; CTRL write beats auto-disable
      step(1'b1, A_COUNT, 32'd0);
      step(1'b1, A_CMP, 32'd0);
      step(1'b1, A_CTRL, 32'h1);
      chk("z_irq_pre", 32'(timer_irq), 32'h0);
      step(1'b1, A_CTRL, 32'h1);
      chk("z_irq", 32'(timer_irq), 32'h1);
      rd(A_CTRL, 32'h5, "z_en_written");
      step(1'b0, A_CTRL, 32'd0);
      rd(A_CTRL, 32'h4, "z_auto_dis");

      // CYCLE load and wrap
      step(1'b1, A_CYCLE, 32'hFFFFFFFE);
      rd(A_CYCLE, 32'hFFFFFFFE, "cyc_load");
      step(1'b0, A_CYCLE, 32'd0);
      rd(A_CYCLE, 32'hFFFFFFFF, "cyc_max");
      step(1'b0, A_CYCLE, 32'd0);
      rd(A_CYCLE, 32'h00000000, "cyc_wrap");

      // Reset mid-count with EN=1, COUNT=5
      step(1'b1, A_CMP, 32'd100);
      step(1'b1, A_COUNT, 32'd5);
      step(1'b1, A_CTRL, 32'h1);
      rd(A_CTRL, 32'h5, "mr_ctrl_pre");
      #2;
      reset = 1'b0;
      #1;
      chk("mr_gpio_out", 32'(gpio_out), 32'h0);
      chk("mr_irq", 32'(timer_irq), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      rd(A_COUNT, 32'h0, "mr_count");
      rd(A_CTRL, 32'h0, "mr_ctrl");
      step(1'b0, A_COUNT, 32'd0);
      step(1'b0, A_COUNT, 32'd0);
      rd(A_COUNT, 32'h0, "mr_stay_off");
      rd(32'h00000008, 32'hDEADBEEF, "mr_ram_kept");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
